uapb_master: RTL and testbench

- APB initiator that drives the UART core's APB slave port (PSEL/PENABLE/PADDR/PWRITE/PWDATA in; PRDATA/PREADY out).
- Converts a simple valid/ready command stream into single APB transfers and returns read data and status on a valid/ready response stream.
- Used by on-chip firmware-less controllers and by the FPGA test harness to configure the baud value and exchange bytes with the UART without a CPU.
- Adds a PREADY wait-state timeout so a hung slave cannot stall the requester.

---
 rtl/uapb_master_if.sv | 42 ++++
 rtl/uapb_master.sv | 101 ++++++++++
 tb/tb_uapb_master.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uapb_master_if.sv
// uapb_master_if: command/response stream plus APB bus bundle for uapb_master.
//   master modport - the uapb_master view (drives APB and the response stream).
//   slave modport  - the opposite side: requester, APB slave model or testbench.
// Signals:
//   cmd_valid/cmd_ready/cmd_write/cmd_addr/cmd_wdata  command stream
//   rsp_valid/rsp_ready/rsp_rdata/rsp_timeout         response stream
//   busy                                               initiator not idle
//   PSEL/PENABLE/PADDR/PWRITE/PWDATA/PRDATA/PREADY     APB bus
interface uapb_master_if #(
  parameter int unsigned BITWIDTH = 8,
  parameter int unsigned ADDR_W   = 2
) ();
  logic                cmd_valid;
  logic                cmd_ready;
  logic                cmd_write;
  logic [ADDR_W-1:0]   cmd_addr;
  logic [BITWIDTH-1:0] cmd_wdata;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [BITWIDTH-1:0] rsp_rdata;
  logic                rsp_timeout;
  logic                busy;
  logic                PSEL;
  logic                PENABLE;
  logic [ADDR_W-1:0]   PADDR;
  logic                PWRITE;
  logic [BITWIDTH-1:0] PWDATA;
  logic [BITWIDTH-1:0] PRDATA;
  logic                PREADY;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, PRDATA, PREADY,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_timeout, busy,
           PSEL, PENABLE, PADDR, PWRITE, PWDATA
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, PRDATA, PREADY,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_timeout, busy,
           PSEL, PENABLE, PADDR, PWRITE, PWDATA
  );
endinterface

// File: rtl/uapb_master.sv
// uapb_master: turns a valid/ready command stream into single APB transfers and
// returns read data/status on a valid/ready response stream. A wait-state
// timeout aborts a transfer whose slave holds PREADY low for TIMEOUT cycles.
// Ports:
//   PCLK    - clock, rising edge
//   PRESET  - synchronous active-high reset
//   bus     - uapb_master_if.master (command, response, busy and APB signals)
// All outputs are registered.
module uapb_master #(
  parameter int unsigned BITWIDTH = 8,
  parameter int unsigned ADDR_W   = 2,
  parameter int unsigned TIMEOUT  = 16,  // 0 disables the timeout
  parameter int unsigned CNT_W    = 5    // 2**CNT_W must exceed TIMEOUT
) (
  input logic           PCLK,
  input logic           PRESET,
  uapb_master_if.master bus
);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_e;

  // Counter value seen on the TIMEOUT-th wait cycle (counter starts at 0).
  localparam logic [CNT_W-1:0] CntLast = CNT_W'(TIMEOUT - 1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q         <= StIdle;
      cnt_q           <= '0;
      bus.cmd_ready   <= 1'b1;
      bus.busy        <= 1'b0;
      bus.PSEL        <= 1'b0;
      bus.PENABLE     <= 1'b0;
      bus.PADDR       <= {ADDR_W{1'b0}};
      bus.PWRITE      <= 1'b0;
      bus.PWDATA      <= {BITWIDTH{1'b0}};
      bus.rsp_valid   <= 1'b0;
      bus.rsp_rdata   <= {BITWIDTH{1'b0}};
      bus.rsp_timeout <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          // cmd_ready is always 1 here, so cmd_valid alone marks the accept.
          if (bus.cmd_valid) begin
            bus.PADDR     <= bus.cmd_addr;
            bus.PWRITE    <= bus.cmd_write;
            bus.PWDATA    <= bus.cmd_wdata;
            bus.PSEL      <= 1'b1;
            bus.PENABLE   <= 1'b0;
            bus.cmd_ready <= 1'b0;
            bus.busy      <= 1'b1;
            state_q       <= StSetup;
          end
        end

        StSetup: begin
          bus.PENABLE <= 1'b1;
          cnt_q       <= '0;
          state_q     <= StAccess;
        end

        StAccess: begin
          // PREADY wins over the timeout on the last allowed wait cycle.
          if (bus.PREADY) begin
            bus.rsp_rdata   <= bus.PWRITE ? {BITWIDTH{1'b0}} : bus.PRDATA;
            bus.rsp_timeout <= 1'b0;
            bus.rsp_valid   <= 1'b1;
            bus.PSEL        <= 1'b0;
            bus.PENABLE     <= 1'b0;
            state_q         <= StResp;
          end else if ((TIMEOUT != 0) && (cnt_q == CntLast)) begin
            bus.rsp_rdata   <= {BITWIDTH{1'b0}};
            bus.rsp_timeout <= 1'b1;
            bus.rsp_valid   <= 1'b1;
            bus.PSEL        <= 1'b0;
            bus.PENABLE     <= 1'b0;
            state_q         <= StResp;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        StResp: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            bus.cmd_ready <= 1'b1;
            bus.busy      <= 1'b0;
            state_q       <= StIdle;
          end
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uapb_master.sv
// tb_uapb_master: self-checking bench for uapb_master (TIMEOUT=4).
// Table vectors with hand-derived expectations, hand sequences for reset,
// throughput and backpressure, then random transfers checked against a
// transfer-level model of the wait/timeout rules.
module tb_uapb_master;
  localparam int TIMEOUT = 4;

  typedef struct {
    logic       w;
    logic [1:0] a;
    logic [7:0] wd;
    int         waits;      // ACCESS cycles with PREADY=0 before PREADY=1
    logic [7:0] prd;
    int         rdelay;     // cycles of rsp_ready=0 before the handshake
    logic       hold_next;  // keep cmd_valid high during the response
    logic [7:0] exp_rd;
    logic       exp_to;
    int         exp_acc;    // ACCESS cycles observed
  } vec_t;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_fail;

  uapb_master_if #(.BITWIDTH(8), .ADDR_W(2)) bus ();

  uapb_master #(
    .BITWIDTH(8),
    .ADDR_W  (2),
    .TIMEOUT (TIMEOUT),
    .CNT_W   (5)
  ) dut (
    .PCLK  (clk),
    .PRESET(rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Transfer-level reference: a slave that stalls `waits` cycles either answers
  // within TIMEOUT ACCESS cycles or the initiator gives up after TIMEOUT.
  function automatic vec_t model(input vec_t v);
    vec_t r;
    r         = v;
    r.exp_to  = (v.waits >= TIMEOUT);
    r.exp_acc = r.exp_to ? TIMEOUT : v.waits + 1;
    r.exp_rd  = (r.exp_to || v.w) ? 8'h00 : v.prd;
    return r;
  endfunction

  // Entered at posedge+1 with the DUT idle; returns idle (or about to accept).
  task automatic run_xfer(input vec_t v);
    int acc;
    chk("idle cmd_ready", bus.cmd_ready, 1);
    chk("idle busy", bus.busy, 0);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = v.w;
    bus.cmd_addr  = v.a;
    bus.cmd_wdata = v.wd;
    bus.PREADY    = 1'($urandom);
    bus.PRDATA    = 8'($urandom);
    step();
    // SETUP: scramble the command to show it was captured at accept.
    bus.cmd_valid = 1'b0;
    bus.cmd_write = ~v.w;
    bus.cmd_addr  = ~v.a;
    bus.cmd_wdata = ~v.wd;
    bus.PREADY    = 1'($urandom);
    chk("setup PSEL", bus.PSEL, 1);
    chk("setup PENABLE", bus.PENABLE, 0);
    chk("setup cmd_ready", bus.cmd_ready, 0);
    chk("setup busy", bus.busy, 1);
    step();
    acc = 0;
    while (bus.PSEL && bus.PENABLE && acc < 40) begin
      acc++;
      chk("access PADDR", bus.PADDR, v.a);
      chk("access PWRITE", bus.PWRITE, v.w);
      chk("access PWDATA", bus.PWDATA, v.wd);
      bus.PREADY = (acc == v.waits + 1);
      bus.PRDATA = bus.PREADY ? v.prd : 8'($urandom);
      step();
    end
    bus.PREADY = 1'($urandom);
    bus.PRDATA = 8'($urandom);
    chk("access cycles", acc, v.exp_acc);
    chk("rsp_valid", bus.rsp_valid, 1);
    chk("rsp_rdata", bus.rsp_rdata, v.exp_rd);
    chk("rsp_timeout", bus.rsp_timeout, v.exp_to);
    chk("resp PSEL", bus.PSEL, 0);
    chk("resp PENABLE", bus.PENABLE, 0);
    chk("resp cmd_ready", bus.cmd_ready, 0);
    chk("resp busy", bus.busy, 1);
    if (v.hold_next) begin
      bus.cmd_valid = 1'b1;
      bus.cmd_write = 1'($urandom);
      bus.cmd_addr  = 2'($urandom);
      bus.cmd_wdata = 8'($urandom);
    end
    for (int i = 0; i < v.rdelay; i++) begin
      bus.rsp_ready = 1'b0;
      step();
      chk("bp rsp_valid", bus.rsp_valid, 1);
      chk("bp rsp_rdata", bus.rsp_rdata, v.exp_rd);
      chk("bp rsp_timeout", bus.rsp_timeout, v.exp_to);
      chk("bp cmd_ready", bus.cmd_ready, 0);
    end
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
    chk("done rsp_valid", bus.rsp_valid, 0);
    chk("done cmd_ready", bus.cmd_ready, 1);
    chk("done busy", bus.busy, 0);
  endtask

  vec_t vecs[6];
  vec_t rv;
  int   acc_cyc[$];

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    //           w     a     wd     waits prd    rdel hold  exp_rd exp_to acc
    vecs[0] = '{1'b1, 2'd1, 8'h35, 0,    8'h00, 0,   1'b0, 8'h00, 1'b0, 1};
    vecs[1] = '{1'b0, 2'd2, 8'h11, 3,    8'hA5, 0,   1'b0, 8'hA5, 1'b0, 4};
    vecs[2] = '{1'b0, 2'd3, 8'h22, 99,   8'h5A, 1,   1'b0, 8'h00, 1'b1, 4};
    vecs[3] = '{1'b1, 2'd0, 8'hC3, 2,    8'h77, 5,   1'b1, 8'h00, 1'b0, 3};
    vecs[4] = '{1'b0, 2'd0, 8'h99, 0,    8'h3C, 1,   1'b0, 8'h3C, 1'b0, 1};
    vecs[5] = '{1'b1, 2'd2, 8'hE1, 99,   8'h44, 0,   1'b0, 8'h00, 1'b1, 4};

    rst           = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.rsp_ready = 1'b0;
    bus.PRDATA    = '0;
    bus.PREADY    = 1'b0;
    step();
    step();
    chk("rst PSEL", bus.PSEL, 0);
    chk("rst PENABLE", bus.PENABLE, 0);
    chk("rst PADDR", bus.PADDR, 0);
    chk("rst PWRITE", bus.PWRITE, 0);
    chk("rst PWDATA", bus.PWDATA, 0);
    chk("rst rsp_valid", bus.rsp_valid, 0);
    chk("rst rsp_rdata", bus.rsp_rdata, 0);
    chk("rst rsp_timeout", bus.rsp_timeout, 0);
    chk("rst busy", bus.busy, 0);
    chk("rst cmd_ready", bus.cmd_ready, 1);
    rst = 1'b0;
    step();

    // Table vectors; vecs[3] holds cmd_valid so vecs[4] is accepted right
    // after the response handshake.
    for (int i = 0; i < 6; i++) run_xfer(vecs[i]);

    // Reset during ACCESS.
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 2'd3;
    bus.PREADY    = 1'b0;
    step();
    bus.cmd_valid = 1'b0;
    step();
    chk("pre-rst PENABLE", bus.PENABLE, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid-rst PSEL", bus.PSEL, 0);
    chk("mid-rst PENABLE", bus.PENABLE, 0);
    chk("mid-rst rsp_valid", bus.rsp_valid, 0);
    chk("mid-rst busy", bus.busy, 0);
    chk("mid-rst cmd_ready", bus.cmd_ready, 1);
    run_xfer('{1'b1, 2'd1, 8'h5E, 1, 8'h00, 0, 1'b0, 8'h00, 1'b0, 2});

    // Reset while a response is pending.
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b0;
    step();
    bus.cmd_valid = 1'b0;
    step();
    bus.PREADY = 1'b1;
    bus.PRDATA = 8'h81;
    step();
    bus.PREADY = 1'b0;
    chk("pre-rst rsp_valid", bus.rsp_valid, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("resp-rst rsp_valid", bus.rsp_valid, 0);
    chk("resp-rst cmd_ready", bus.cmd_ready, 1);
    chk("resp-rst busy", bus.busy, 0);
    run_xfer('{1'b0, 2'd2, 8'h00, 0, 8'h6D, 0, 1'b0, 8'h6D, 1'b0, 1});

    // Back-to-back throughput with rsp_ready and PREADY tied high.
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b1;
    bus.cmd_addr  = 2'd1;
    bus.cmd_wdata = 8'h0F;
    bus.rsp_ready = 1'b1;
    bus.PREADY    = 1'b1;
    for (int c = 0; c < 13; c++) begin
      if (bus.cmd_ready) acc_cyc.push_back(c);
      step();
    end
    bus.cmd_valid = 1'b0;
    chk("tput accepts", acc_cyc.size(), 4);
    for (int i = 1; i < acc_cyc.size(); i++)
      chk("tput interval", acc_cyc[i] - acc_cyc[i-1], 4);
    for (int c = 0; c < 8 && bus.busy; c++) step();
    bus.rsp_ready = 1'b0;
    bus.PREADY    = 1'b0;
    chk("tput drained", bus.busy, 0);

    // Random transfers against the model.
    for (int i = 0; i < 30; i++) begin
      rv.w         = 1'($urandom);
      rv.a         = 2'($urandom);
      rv.wd        = 8'($urandom);
      rv.waits     = $urandom_range(0, 6);
      rv.prd       = 8'($urandom);
      rv.rdelay    = $urandom_range(0, 2);
      rv.hold_next = 1'b0;
      run_xfer(model(rv));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected bench completion");
    $fatal(1, "bench timed out");
  end
endmodule
